// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope feeding the pwm block: emits {period, duty}, where
// duty is the envelope level scaled into the note period latched at key-down.
module adsr_envelope #(
    parameter int TICK_DIV = 1000,
    parameter int PRESC_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gate,
    input  logic [7:0]  note_period,
    input  logic [7:0]  attack_rate,
    input  logic [7:0]  decay_rate,
    input  logic [7:0]  sustain_level,
    input  logic [7:0]  release_rate,
    output logic [15:0] pwm_reg,
    output logic [7:0]  env_level,
    output logic        active
);

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } state_t;

    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

    state_t              state, state_next;
    logic [7:0]          level_next;
    logic [7:0]          period_q;
    logic                gate_q;
    logic [PRESC_W-1:0]  prescaler;
    logic                tick;
    logic                rise, fall;
    logic [8:0]          attack_sum;
    logic [7:0]          attack_sat;
    logic [7:0]          decay_room;
    logic [15:0]         product;

    assign tick       = (prescaler == TICK_LAST);
    assign rise       = gate & ~gate_q;
    assign fall       = ~gate & gate_q;
    assign attack_sum = {1'b0, env_level} + {1'b0, attack_rate};
    assign attack_sat = attack_sum[8] ? 8'hFF : attack_sum[7:0];
    // Only meaningful when env_level > sustain_level, which is when DECAY subtracts.
    assign decay_room = env_level - sustain_level;
    assign product    = 16'(env_level) * 16'(period_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            env_level <= 8'd0;
            period_q  <= 8'd0;
            gate_q    <= 1'b0;
            prescaler <= '0;
            pwm_reg   <= 16'h0000;
            active    <= 1'b0;
        end else begin
            state     <= state_next;
            env_level <= level_next;
            gate_q    <= gate;
            prescaler <= tick ? '0 : prescaler + PRESC_W'(1);
            if (rise) begin
                period_q <= note_period;
            end
            pwm_reg   <= {period_q, product[15:8]};
            active    <= (state != IDLE);
        end
    end

    // NOTE: both outputs of this block get a default first so no path can
    // leave them unassigned and infer a latch.
    always_comb begin
        state_next = state;
        level_next = env_level;
        if (rise) begin
            // Retrigger keeps the current level to avoid an audible click.
            state_next = ATTACK;
        end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_next = RELEASE;
        end else if (tick) begin
            unique case (state)
                ATTACK: begin
                    level_next = attack_sat;
                    if (attack_sat == 8'hFF) begin
                        state_next = DECAY;
                    end
                end
                DECAY: begin
                    if (env_level <= sustain_level) begin
                        level_next = sustain_level;
                        state_next = SUSTAIN;
                    end else if (decay_rate >= decay_room) begin
                        level_next = sustain_level;
                    end else begin
                        level_next = env_level - decay_rate;
                    end
                end
                SUSTAIN: level_next = sustain_level;
                RELEASE: begin
                    if (release_rate >= env_level) begin
                        level_next = 8'd0;
                        state_next = IDLE;
                    end else begin
                        level_next = env_level - release_rate;
                    end
                end
                default: level_next = 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed envelope scenarios plus random
// gate/rate traffic, all compared each clock against an arithmetic envelope model.
module tb_adsr_envelope;

    localparam int TICK_DIV = 4;

    localparam int P_IDLE    = 0;
    localparam int P_ATTACK  = 1;
    localparam int P_DECAY   = 2;
    localparam int P_SUSTAIN = 3;
    localparam int P_RELEASE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        gate;
    logic [7:0]  note_period;
    logic [7:0]  attack_rate;
    logic [7:0]  decay_rate;
    logic [7:0]  sustain_level;
    logic [7:0]  release_rate;
    logic [15:0] pwm_reg;
    logic [7:0]  env_level;
    logic        active;

    int checks   = 0;
    int failures = 0;

    // Model: envelope phase, level, latched period, last gate, cycles into the tick window.
    int m_phase, m_level, m_period, m_count, m_pwm, m_active;
    bit m_gate_prev;

    adsr_envelope #(.TICK_DIV(TICK_DIV), .PRESC_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .gate          (gate),
        .note_period   (note_period),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .pwm_reg       (pwm_reg),
        .env_level     (env_level),
        .active        (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Advance the model by one rising edge using the inputs presented at that edge.
    task automatic model_step();
        bit tick_now, rise, fall;
        if (reset) begin
            m_phase = P_IDLE; m_level = 0; m_period = 0; m_count = 0;
            m_gate_prev = 1'b0; m_pwm = 0; m_active = 0;
        end else begin
            m_pwm    = m_period * 256 + (m_level * m_period) / 256;
            m_active = (m_phase != P_IDLE);
            tick_now = (m_count == TICK_DIV - 1);
            m_count  = (m_count + 1) % TICK_DIV;
            rise = gate && !m_gate_prev;
            fall = !gate && m_gate_prev;
            m_gate_prev = gate;
            if (rise) begin
                m_phase  = P_ATTACK;
                m_period = note_period;
            end else if (fall && m_phase inside {P_ATTACK, P_DECAY, P_SUSTAIN}) begin
                m_phase = P_RELEASE;
            end else if (tick_now) begin
                case (m_phase)
                    P_ATTACK: begin
                        m_level = imin(m_level + attack_rate, 255);
                        if (m_level == 255) m_phase = P_DECAY;
                    end
                    P_DECAY: begin
                        if (m_level <= sustain_level) begin
                            m_level = sustain_level;
                            m_phase = P_SUSTAIN;
                        end else begin
                            m_level = imax(m_level - decay_rate, sustain_level);
                        end
                    end
                    P_SUSTAIN: m_level = sustain_level;
                    P_RELEASE: begin
                        m_level = imax(m_level - release_rate, 0);
                        if (m_level == 0) m_phase = P_IDLE;
                    end
                    default: m_level = 0;
                endcase
            end
        end
    endtask

    // One clock: let the edge happen, sample 1 time unit later, compare with the model.
    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        check("env_level", env_level, m_level);
        check("active", active, m_active);
        check("pwm_reg", pwm_reg, m_pwm);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        reset = 1'b1; gate = 1'b0; note_period = 8'd0;
        attack_rate = 8'd64; decay_rate = 8'd32; sustain_level = 8'd100; release_rate = 8'd40;
        m_phase = P_IDLE; m_level = 0; m_period = 0; m_count = 0;
        m_gate_prev = 1'b0; m_pwm = 0; m_active = 0;

        // Reset, then a long idle stretch.
        run(2);
        check("reset_pwm", pwm_reg, 0);
        reset = 1'b0;
        run(50);
        check("idle_level", env_level, 0);
        check("idle_active", active, 0);

        // Attack -> decay -> sustain at 100 on a period of 200.
        gate = 1'b1; note_period = 8'd200;
        run(60);
        check("sustain_level", env_level, 100);
        check("sustain_pwm", pwm_reg, {8'd200, 8'd78});

        // Release to idle, period byte retained.
        gate = 1'b0;
        run(30);
        check("release_level", env_level, 0);
        check("release_active", active, 0);
        check("release_pwm", pwm_reg, {8'd200, 8'd0});

        // Hold at 150 in RELEASE (rate 0), then retrigger on a tick edge.
        sustain_level = 8'd150; release_rate = 8'd0; gate = 1'b1;
        run(60);
        gate = 1'b0;
        run(5);
        check("hold_150", env_level, 150);
        for (int i = 0; i < TICK_DIV && m_count != TICK_DIV - 1; i++) cyc();
        gate = 1'b1; note_period = 8'd100;
        cyc();
        check("retrig_keep", env_level, 150);
        run(TICK_DIV);
        check("retrig_214", env_level, 214);
        run(TICK_DIV);
        check("retrig_255", env_level, 255);
        check("retrig_period", pwm_reg[15:8], 100);

        // Zero attack rate holds the level at 0 while active.
        release_rate = 8'd255; gate = 1'b0;
        run(20);
        attack_rate = 8'd0; gate = 1'b1;
        run(20 * TICK_DIV);
        check("zero_atk_level", env_level, 0);
        check("zero_atk_active", active, 1);

        // Sustain at 255: DECAY hands over to SUSTAIN on its first tick.
        gate = 1'b0;
        run(8);
        attack_rate = 8'd255; decay_rate = 8'd10; sustain_level = 8'd255; gate = 1'b1;
        run(6 * TICK_DIV);
        check("sus255_level", env_level, 255);

        // One-clock gate pulse: ATTACK then RELEASE on consecutive edges.
        gate = 1'b0; release_rate = 8'd1;
        run(3);
        gate = 1'b1;
        cyc();
        gate = 1'b0;
        run(4);

        // Mid-attack reset with the gate held high, then re-attack from 0.
        reset = 1'b1;
        cyc();
        reset = 1'b0; attack_rate = 8'd64; gate = 1'b1;
        for (int i = 0; i < 100 && m_level != 128; i++) cyc();
        check("reach_128", env_level, 128);
        reset = 1'b1;
        cyc();
        check("mid_rst_level", env_level, 0);
        check("mid_rst_pwm", pwm_reg, 0);
        check("mid_rst_active", active, 0);
        reset = 1'b0;
        cyc();
        run(3);
        check("reattack_64", env_level, 64);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) gate = ~gate;
            if ($urandom_range(7) == 0) note_period = 8'($urandom);
            if ($urandom_range(49) == 0) begin
                attack_rate   = 8'($urandom_range(3) == 0 ? 0 : $urandom);
                decay_rate    = 8'($urandom_range(3) == 0 ? 0 : $urandom);
                sustain_level = 8'($urandom);
                release_rate  = 8'($urandom_range(3) == 0 ? 0 : $urandom);
            end
            reset = ($urandom_range(499) == 0);
            cyc();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Upstream control stage for the pwm block: generates the 16-bit pwm_reg word {period, duty} from a note period and a gate (key-held) signal.
- Applies an attack/decay/sustain/release amplitude envelope: the duty byte is the envelope level scaled into the current note period, so loudness follows the envelope.
- Output pwm_reg connects directly to the pwm block's pwm_reg input.

Parameters:
- TICK_DIV, 1000, clocks per envelope step; the legal range is 2..65535.
- PRESC_W, 16, prescaler counter width; it must hold TICK_DIV-1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- gate  input  1  note on/off; high while the key is held.
- note_period  input  8  PWM period byte; latched on the gate rising edge.
- attack_rate  input  8  level increment per tick in ATTACK; 0 holds the level.
- decay_rate  input  8  level decrement per tick in DECAY; 0 holds the level.
- sustain_level  input  8  level target and hold value for DECAY/SUSTAIN.
- release_rate  input  8  level decrement per tick in RELEASE; 0 holds the level.
- pwm_reg  output  16  [15:8] = latched period, [7:0] = scaled duty.
- env_level  output  8  current envelope level, 0..255.
- active  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE, env_level=0, period_q=0, gate_q=0, prescaler=0.
  - pwm_reg=16'h0000, active=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 for one clock when prescaler==TICK_DIV-1.
  - Free-running; it is not restarted by gate events.
- Gate edge detection: gate_q registers gate each clock; rise = gate & ~gate_q; fall = ~gate & gate_q.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Gate events, evaluated every clock with priority over tick updates:
  - rise, from any state: state→ATTACK, period_q←note_period. env_level is unchanged (retrigger starts from the current level, no click to zero). A level update is suppressed on that edge even if tick=1.
  - fall while in ATTACK/DECAY/SUSTAIN: state→RELEASE. env_level is unchanged on that edge.
  - fall in IDLE or RELEASE: no effect.
- Tick updates (tick=1 and no gate event on that edge):
  - ATTACK: level←min(level+attack_rate, 255), using a 9-bit sum. If the result equals 255, state→DECAY.
  - DECAY: if level ≤ sustain_level (checked before subtracting), level←sustain_level and state→SUSTAIN. Otherwise level←max(level-decay_rate, sustain_level).
  - SUSTAIN: level←sustain_level, so a changed sustain_level is tracked once per tick.
  - RELEASE: level←max(level-release_rate, 0), computed without wrap. If the result is 0, state→IDLE.
  - IDLE: level stays 0.
- Rate 0: the level never moves in that state. This is legal; the state persists until a gate event (or, in DECAY, until the level already equals sustain_level).
- Duty scaling:
  - duty = (env_level × period_q) >> 8, using a 16-bit product with the upper byte taken.
  - This guarantees duty ≤ period_q.
  - period_q=0 gives duty=0.
- Output timing:
  - pwm_reg and active are registered from state/env_level/period_q: one clock latency after an env_level or period change.
  - env_level is the state register itself (zero latency).
- Mid-operation reset returns to IDLE with all outputs zero on the next edge, regardless of gate. A gate held high through reset release counts as a rise, because gate_q=0 after reset.

Test Plan:
- Reset then idle: reset=1 for 2 clocks, then gate=0 for 50 clocks → pwm_reg=0, env_level=0, active=0 throughout.
- Attack/decay/sustain, with TICK_DIV=4, note_period=200, attack=64, decay=32, sustain=100:
  - Raise gate → ATTACK.
  - Level sequence on ticks: 64, 128, 192, 255 (→DECAY), then 223, 191, 159, 127, 100 (→SUSTAIN).
  - In SUSTAIN, pwm_reg = {8'd200, 8'd78}, since (100×200)>>8 = 78.
- Release to idle: from SUSTAIN at level 100 with release=40, drop gate → RELEASE.
  - Levels 60, 20, 0 on successive ticks, then IDLE, active=0 one clock after IDLE.
  - pwm_reg[7:0]=0, pwm_reg[15:8] stays 200.
- Retrigger: with level 150 in RELEASE, raise gate with note_period=100 → ATTACK, and the level stays 150 on that edge even if coincident with tick.
  - With attack=64, the next ticks give 214, then 255 (saturated).
  - pwm_reg[15:8]=100.
- Zero rate / edge cases:
  - attack_rate=0 holding gate for 20 ticks → level stays 0, state ATTACK, active=1.
  - sustain_level=255 → DECAY moves to SUSTAIN on the first tick with level 255.
  - A gate pulse of 1 clock → ATTACK then RELEASE on consecutive edges, with level unchanged.
- Mid-operation reset: assert reset during ATTACK at level 128 with gate held high → all outputs 0 on the next edge. After release, a rise is detected and ATTACK starts from 0.
